// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU (AND/OR/ADD/SLT slice semantics, a/b invert), one result bit per clock, LSB first.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E(WIDTH+1) (WIDTH+2 edges inclusive).
// Backpressure: none; start is only sampled in IDLE, and a start seen while busy or in the done cycle is dropped.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request strobe, sampled in IDLE only
//   a, b                WIDTH-bit operands, latched on the accepting edge
//   op                  {ainvert, binvert, ctl[1:0]}; ctl 0=AND 1=OR 2=ADD 3=SLT
//   busy                high from the accepting edge until the done cycle
//   done                one-cycle pulse when result/zero/cout/overflow are valid
//   result, zero        final result and its zero flag, held until the next accepted start
//   cout, overflow      carry out of MSB and signed overflow for ctl 2/3, else 0
module alu_serial_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;

   // Operands and operation captured at acceptance; later input changes are ignored.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             ainv_q;
   logic             binv_q;
   logic [1:0]       ctl_q;

   logic [CW-1:0]    cnt;
   logic             carry;

   // Values captured while processing the MSB, consumed in FIX.
   logic             cin_msb;
   logic             sum_msb;
   logic             cout_msb;

   // Current slice signals
   logic             abit;
   logic             bbit;
   logic             sum_bit;
   logic             maj_bit;
   logic             r_bit;
   logic             arith;

   // FIX-stage signals
   logic             ovf_fix;
   logic [WIDTH-1:0] res_fix;

   always_comb begin
      abit    = a_q[cnt] ^ ainv_q;
      bbit    = b_q[cnt] ^ binv_q;
      sum_bit = abit ^ bbit ^ carry;
      maj_bit = (abit & bbit) | (abit & carry) | (bbit & carry);
      arith   = ctl_q[1];
      case (ctl_q)
         2'd0:    r_bit = abit & bbit;
         2'd1:    r_bit = abit | bbit;
         2'd2:    r_bit = sum_bit;
         default: r_bit = 1'b0;   // SLT: "less" input is 0 for every slice
      endcase
   end

   // Signed overflow is carry-in to MSB xor carry-out; SLT takes the
   // overflow-corrected sign of a'-b' into bit 0.
   always_comb begin
      ovf_fix = cin_msb ^ cout_msb;
      res_fix = result;
      if (ctl_q == 2'd3) begin
         res_fix[0] = sum_msb ^ ovf_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ainv_q   <= 1'b0;
         binv_q   <= 1'b0;
         ctl_q    <= 2'd0;
         cnt      <= '0;
         carry    <= 1'b0;
         cin_msb  <= 1'b0;
         sum_msb  <= 1'b0;
         cout_msb <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  ainv_q   <= op[3];
                  binv_q   <= op[2];
                  ctl_q    <= op[1:0];
                  cnt      <= '0;
                  // binvert doubles as carry-in so that a + ~b + 1 forms a - b
                  carry    <= op[2];
                  result   <= '0;
                  zero     <= 1'b0;
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end

            S_RUN: begin
               result[cnt] <= r_bit;
               if (arith) begin
                  carry <= maj_bit;
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  cin_msb  <= carry;
                  sum_msb  <= sum_bit;
                  cout_msb <= maj_bit;
                  state    <= S_FIX;
               end
            end

            S_FIX: begin
               result   <= res_fix;
               zero     <= (res_fix == '0);
               cout     <= arith & cout_msb;
               overflow <= arith & ovf_fix;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= S_DONE;
            end

            S_DONE: begin
               // start is deliberately not sampled here
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
